key_debounce_multi: RTL
=======================

# key_debounce_multi

Parametrised multi-channel push-button conditioner between raw board key pins and the user-logic control path. Each channel synchronises its key input, samples it on a shared prescaled tick, and commits a new debounced level only after DEB_CNT consecutive samples disagree with the current level. Per channel it produces the debounced level plus single-cycle press, release and long-press event pulses, so downstream logic needs no edge detection of its own.

## Interface
- CH_NUM, 4: number of independent key channels (≥1).
- CLK_DIV, 1000: CLK cycles per sample tick (≥1; 1 = sample every cycle).
- DEB_CNT, 4: consecutive differing samples required to commit a level change (≥1).
- LONG_CNT, 500: samples a key must stay pressed, counted from the press commit, to fire KEY_Long (≥1).
- KEY_ACTIVE, 1'b0: pin level meaning "pressed" (keys active-low by default).

- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-low reset.
- KEY_In  input  CH_NUM  raw asynchronous key pins.
- KEY_Level  output  CH_NUM  debounced pin level; reset value ~KEY_ACTIVE on all bits (released).
- KEY_Press  output  CH_NUM  1-cycle pulse per bit on committed press; reset 0.
- KEY_Release  output  CH_NUM  1-cycle pulse per bit on committed release; reset 0.
- KEY_Long  output  CH_NUM  1-cycle pulse per bit when a press has lasted LONG_CNT samples; reset 0.
- Sample_Tick  output  1  1-cycle pulse marking each sample instant; reset 0.

## Operation
- Reset: synchroniser flops, KEY_Level and all debounce counters load released state (~KEY_ACTIVE), all counters 0, all pulse outputs 0. Reset mid-debounce or mid-hold discards progress; no pulses are emitted for the interrupted press.
- Synchroniser: 2 flops per channel; sampled value = second flop.
- Prescaler: counts 0..CLK_DIV-1 and wraps. Tick is high in the cycle where count == CLK_DIV-1. Prescaler width is $clog2(CLK_DIV), minimum 1. Sample_Tick is the registered tick.
- Per channel, on Sample_Tick:
  - sample != KEY_Level: deb_cnt += 1; when the increment reaches DEB_CNT, KEY_Level <= sample and deb_cnt <= 0.
  - sample == KEY_Level: deb_cnt <= 0. Any agreeing sample restarts the count; glitches shorter than DEB_CNT ticks never reach the output.
- Events, registered on the same edge that updates KEY_Level:
  - KEY_Press fires when KEY_Level commits to KEY_ACTIVE.
  - KEY_Release fires when KEY_Level commits to ~KEY_ACTIVE.
- Long press: hold_cnt clears on the press commit. On each later tick while KEY_Level == KEY_ACTIVE, it increments and saturates at LONG_CNT. KEY_Long pulses once, on the tick where hold_cnt reaches LONG_CNT. No further KEY_Long fires until a release and a new press. Release clears hold_cnt; KEY_Release still fires for a long press.
- Channels are fully independent. Simultaneous events on several channels assert several bits in the same cycle.
- Counter widths: deb_cnt is $clog2(DEB_CNT+1) bits and hold_cnt is $clog2(LONG_CNT+1) bits; neither counter wraps.

## Timing
- Pulses are exactly one CLK cycle wide, including CLK_DIV = 1.
- Between ticks, KEY_Level, deb_cnt and hold_cnt hold their values.
- Press latency, from a clean KEY_In edge to KEY_Level/KEY_Press: 2 cycles of synchroniser, plus the wait to the next tick, plus (DEB_CNT-1)·CLK_DIV cycles, plus 1 registering cycle. The bound is 3 + DEB_CNT·CLK_DIV cycles.
- KEY_Long asserts exactly LONG_CNT ticks after the KEY_Press cycle.

## Test plan
Common parameters: CH_NUM=2, CLK_DIV=4, DEB_CNT=3, LONG_CNT=5, KEY_ACTIVE=0.
- Reset release with KEY_In=2'b11 -> KEY_Level=2'b11, no pulses for 50 cycles, and Sample_Tick every 4 cycles.
- Drive KEY_In[0]=0 and hold it -> KEY_Level[0]=0 and a single-cycle KEY_Press[0] within 15 cycles, on the 3rd tick after the synchronised low; channel 1 stays unchanged.
- Drive KEY_In[0] low for 2 ticks, high for 1 tick, repeated 10 times -> KEY_Level[0] stays 1 and no pulses occur.
- Hold KEY_In[1]=0 -> KEY_Press[1], then KEY_Long[1] exactly 5 ticks (20 cycles) later, only once over 100 cycles. Then release -> KEY_Release[1] once.
- Press both keys in the same cycle -> KEY_Press=2'b11 in one cycle. Then release both -> KEY_Release=2'b11 in one cycle.
- Assert RST after 2 debounce ticks of a press or 3 hold ticks, then deassert with KEY_In high -> all outputs at reset values, and no KEY_Press or KEY_Long afterwards.

Source files
------------

// File: rtl/key_debounce_multi.sv
// Multi-channel key conditioner: 2-flop synchroniser, shared sample prescaler,
// per-channel debounce with press/release/long-press single-cycle event pulses.
module key_debounce_multi #(
  parameter int   CH_NUM     = 4,
  parameter int   CLK_DIV    = 1000,
  parameter int   DEB_CNT    = 4,
  parameter int   LONG_CNT   = 500,
  parameter logic KEY_ACTIVE = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CH_NUM-1:0] KEY_In,
  output logic [CH_NUM-1:0] KEY_Level,
  output logic [CH_NUM-1:0] KEY_Press,
  output logic [CH_NUM-1:0] KEY_Release,
  output logic [CH_NUM-1:0] KEY_Long,
  output logic              Sample_Tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int HW = $clog2(LONG_CNT + 1);

  localparam logic [PW-1:0]     DIV_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]     DIV_ONE  = PW'(1);
  localparam logic [DW-1:0]     DEB_LAST = DW'(DEB_CNT - 1);
  localparam logic [DW-1:0]     DEB_ONE  = DW'(1);
  localparam logic [HW-1:0]     HOLD_MAX = HW'(LONG_CNT);
  localparam logic [HW-1:0]     HOLD_ONE = HW'(1);
  localparam logic [CH_NUM-1:0] RELEASED = {CH_NUM{~KEY_ACTIVE}};

  logic [PW-1:0]               div_cnt;
  logic                        tick;
  logic [CH_NUM-1:0]           sync_q1;
  logic [CH_NUM-1:0]           sync_q2;
  logic [CH_NUM-1:0][DW-1:0]   deb_cnt;
  logic [CH_NUM-1:0][HW-1:0]   hold_cnt;

  assign tick = (div_cnt == DIV_LAST);

  // With CLK_DIV = 1 the counter sits at 0 and tick is permanently high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_cnt     <= '0;
      Sample_Tick <= 1'b0;
    end else begin
      Sample_Tick <= tick;
      div_cnt     <= tick ? '0 : div_cnt + DIV_ONE;
    end
  end

  // Synchroniser resets to the released level so no phantom press follows reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q1 <= RELEASED;
      sync_q2 <= RELEASED;
    end else begin
      sync_q1 <= KEY_In;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      KEY_Level   <= RELEASED;
      KEY_Press   <= '0;
      KEY_Release <= '0;
      KEY_Long    <= '0;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
    end else begin
      KEY_Press   <= '0;
      KEY_Release <= '0;
      KEY_Long    <= '0;
      if (Sample_Tick) begin
        for (int i = 0; i < CH_NUM; i++) begin
          if ((sync_q2[i] != KEY_Level[i]) && (deb_cnt[i] == DEB_LAST)) begin
            KEY_Level[i] <= sync_q2[i];
            deb_cnt[i]   <= '0;
            hold_cnt[i]  <= '0;
            if (sync_q2[i] == KEY_ACTIVE) begin
              KEY_Press[i] <= 1'b1;
            end else begin
              KEY_Release[i] <= 1'b1;
            end
          end else begin
            deb_cnt[i] <= (sync_q2[i] != KEY_Level[i]) ? deb_cnt[i] + DEB_ONE : '0;
            // Saturating hold counter gives exactly one long pulse per press.
            if ((KEY_Level[i] == KEY_ACTIVE) && (hold_cnt[i] != HOLD_MAX)) begin
              hold_cnt[i] <= hold_cnt[i] + HOLD_ONE;
              if (hold_cnt[i] == HOLD_MAX - HOLD_ONE) begin
                KEY_Long[i] <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

endmodule
